// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter sharing one multi-cycle ALU
module alu_arbiter #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_a_or_l,
  input  logic        req0_s_or_u,
  input  logic [1:0]  req0_opcode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_a_or_l,
  input  logic        req1_s_or_u,
  input  logic [1:0]  req1_opcode,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_a_or_l,
  output logic        alu_s_or_u,
  output logic [1:0]  alu_opcode,
  input  logic [31:0] alu_answer,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(ALU_LATENCY);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_last;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_alu_a_or_l;
  logic        r_alu_s_or_u;
  logic [1:0]  r_alu_opcode;
  logic [31:0] r_res0;
  logic [31:0] r_res1;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_sel;
  logic w_rsp_hs;
  logic w_cnt_done;

  // On a tie the requester that was not served last wins; r_last resets to 1 so req0 wins first.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_grant0   = req0_valid & (~req1_valid | r_last);
  assign w_grant1   = req1_valid & (~req0_valid | ~r_last);
  assign req0_ready = rst_n & w_idle & w_grant0;
  assign req1_ready = rst_n & w_idle & w_grant1;

  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_sel      = req1_valid & req1_ready;
  assign w_rsp_hs   = r_owner ? rsp1_ready : rsp0_ready;
  assign w_cnt_done = (r_cnt == 4'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_next = ST_EXEC;
      ST_EXEC: if (w_cnt_done) w_next = ST_RESP;
      ST_RESP: if (w_rsp_hs)   w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_a_or_l <= 1'b0;
      r_alu_s_or_u <= 1'b0;
      r_alu_opcode <= 2'd0;
      r_res0       <= 32'd0;
      r_res1       <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt        <= LAT_CNT;
        r_owner      <= w_sel;
        r_last       <= w_sel;
        r_alu_a      <= w_sel ? req1_a      : req0_a;
        r_alu_b      <= w_sel ? req1_b      : req0_b;
        r_alu_a_or_l <= w_sel ? req1_a_or_l : req0_a_or_l;
        r_alu_s_or_u <= w_sel ? req1_s_or_u : req0_s_or_u;
        r_alu_opcode <= w_sel ? req1_opcode : req0_opcode;
      end else if (r_state == ST_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_cnt_done) begin
          if (r_owner) r_res1 <= alu_answer;
          else         r_res0 <= alu_answer;
        end
      end
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_a_or_l  = r_alu_a_or_l;
  assign alu_s_or_u  = r_alu_s_or_u;
  assign alu_opcode  = r_alu_opcode;
  assign rsp0_valid  = (r_state == ST_RESP) & ~r_owner;
  assign rsp1_valid  = (r_state == ST_RESP) & r_owner;
  assign rsp0_result = r_res0;
  assign rsp1_result = r_res1;
  assign busy        = ~w_idle;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LATENCY, default 1, rising edges from operand issue to a valid alu_answer; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  (N=0,1) arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  (N=0,1) operands.
REQ-007 reqN_a_or_l, reqN_s_or_u  input  1 each  (N=0,1) arithmetic/logic select; signed/unsigned select.
REQ-008 reqN_opcode  input  2  (N=0,1) ALU opcode.
REQ-009 rspN_valid  output  1  (N=0,1) result for requester N available.
REQ-010 rspN_ready  input  1  (N=0,1) requester N takes the result.
REQ-011 rspN_result  output  32  (N=0,1) ALU result.
REQ-012 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-013 alu_a_or_l, alu_s_or_u  output  1 each; alu_opcode  output  2  ALU control.
REQ-014 alu_answer  input  32  ALU result.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL share one ALU between two requesters via a three-state FSM: IDLE, EXEC, RESP.
REQ-017 In IDLE, reqN_ready SHALL equal grant N: only one valid -> that one granted; both valid -> the requester not granted last (round-robin); none valid -> both ready low.
REQ-018 reqN_ready SHALL be low in EXEC and RESP.
REQ-019 A handshake (reqN_valid & reqN_ready at an edge) SHALL latch a, b, a_or_l, s_or_u, opcode into the alu_* output registers, record owner N, update last-grant to N, load the latency counter with ALU_LATENCY, and enter EXEC.
REQ-020 alu_* outputs SHALL be registered, stable from the accept edge until the next accept, and hold their last value in IDLE.
REQ-021 In EXEC the counter SHALL decrement each edge; on the edge where it reaches zero (the ALU_LATENCY-th edge after accept) alu_answer SHALL be captured into the owner's result register and the FSM SHALL enter RESP.
REQ-022 In RESP, rsp<owner>_valid SHALL be high, the other rspN_valid low; rspN_result SHALL hold the captured value until handshake.
REQ-023 On the edge with rsp<owner>_valid & rsp<owner>_ready, the FSM SHALL return to IDLE, and rspN_valid SHALL be low the following cycle; the next accept can occur no earlier than the edge after that.
REQ-024 Minimum issue interval with rspN_ready held high SHALL be ALU_LATENCY+2 cycles.
REQ-025 rspN_ready while rspN_valid is low SHALL be ignored; a request whose valid drops before acceptance SHALL have no effect.
REQ-026 Requests arriving in EXEC/RESP SHALL wait (no loss, no reordering of the arbitration rule).
REQ-027 The non-owner's rspN_result SHALL retain its previous value.

Reset
REQ-028 While rst_n is low: state IDLE, counter 0, last-grant = 1 (req0 wins first tie), reqN_ready and rspN_valid 0, rspN_result 0, alu_* outputs 0, busy 0.
REQ-029 Reset asserted mid-EXEC or mid-RESP SHALL abandon the operation immediately with no response issued after release.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-031 LAT=1, req0: a=62, b=15, a_or_l=0, s_or_u=0, opcode=00, ALU model adds; rsp ready high -> req0_ready in accept cycle, rsp0_valid one edge later with result 77, busy high 2 cycles.
REQ-032 Both valid from reset, continuous -> grants 0,1,0,1; each issue exactly LAT+2 cycles apart; rsp valid only to the granted owner.
REQ-033 LAT=3, rsp0_ready held low 5 cycles -> rsp0_valid and result stable throughout, req1_ready stays low, req1 accepted on the edge after rsp handshake + 1.
REQ-034 rst_n pulsed low during EXEC -> all outputs 0 asynchronously, no rspN_valid after release, next request accepted normally.
REQ-035 Requester raises valid for one cycle while busy then drops -> never accepted, no response.
REQ-036 Operand change on req inputs after accept -> alu_* outputs unchanged until next accept.
